// File: rtl/decoder_pkg.sv
// Shared constants for the registered one-hot decoder.
package decoder_pkg;

  localparam int IP_WIDTH_DEFAULT = 4;

  // Width of the one-hot word produced from a w-bit index.
  function automatic int op_width(input int w);
    return 1 << w;
  endfunction

endpackage

// File: rtl/decoder_core.sv
// Combinational one-hot generator: next_y[k] = en & (i == k).
module decoder_core
  import decoder_pkg::*;
#(
  parameter  int IP_WIDTH = IP_WIDTH_DEFAULT,
  localparam int OP_WIDTH = op_width(IP_WIDTH)
) (
  input  logic                en,
  input  logic [IP_WIDTH-1:0] i,
  output logic [OP_WIDTH-1:0] next_y
);

  always_comb begin
    // NOTE: default the whole word first so no path through this block leaves a bit unassigned (no latch).
    next_y = '0;
    if (en) next_y[i] = 1'b1;
  end

endmodule

// File: rtl/decoder.sv
// Registered binary-to-one-hot decoder with enable; y and y_vld are one cycle behind en/i.
module decoder
  import decoder_pkg::*;
#(
  parameter  int IP_WIDTH = IP_WIDTH_DEFAULT,
  localparam int OP_WIDTH = op_width(IP_WIDTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [IP_WIDTH-1:0] i,
  output logic [OP_WIDTH-1:0] y,
  output logic                y_vld
);

  logic [OP_WIDTH-1:0] next_y;

  decoder_core #(
    .IP_WIDTH(IP_WIDTH)
  ) u_core (
    .en    (en),
    .i     (i),
    .next_y(next_y)
  );

  // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y     <= '0;
      y_vld <= 1'b0;
    end else begin
      y     <= next_y;
      y_vld <= en;
    end
  end

  // Output is either idle (all zero, not valid) or a single valid select line.
  a_one_hot : assert property (
    @(posedge clk) disable iff (rst)
      $onehot0(y) && (y_vld == (y != '0))
  );

endmodule

// File: tb/tb_decoder.sv
// Scoreboard bench for decoder at IP_WIDTH 4, 1 and 8 driven in lock-step.
`timescale 1ns/1ps
module tb_decoder;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en  = 1'b0;
  logic [3:0]   i4  = '0;
  logic         i1  = 1'b0;
  logic [7:0]   i8  = '0;
  logic [15:0]  y4;
  logic [1:0]   y1;
  logic [255:0] y8;
  logic         vld4, vld1, vld8;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic         vld;
    logic [15:0]  y4;
    logic [1:0]   y1;
    logic [255:0] y8;
  } exp_t;

  exp_t sb[$];

  decoder #(.IP_WIDTH(4)) dut4 (.clk(clk), .rst(rst), .en(en), .i(i4), .y(y4), .y_vld(vld4));
  decoder #(.IP_WIDTH(1)) dut1 (.clk(clk), .rst(rst), .en(en), .i(i1), .y(y1), .y_vld(vld1));
  decoder #(.IP_WIDTH(8)) dut8 (.clk(clk), .rst(rst), .en(en), .i(i8), .y(y8), .y_vld(vld8));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Inputs change on the falling edge; the expectation belongs to the next rising edge.
  task automatic drive(input logic e, input logic [3:0] a4, input logic a1, input logic [7:0] a8,
                       input logic [15:0] e4, input logic [1:0] e1, input logic [255:0] e8);
    exp_t x;
    @(negedge clk);
    en = e; i4 = a4; i1 = a1; i8 = a8;
    x.vld = e; x.y4 = e4; x.y1 = e1; x.y8 = e8;
    sb.push_back(x);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_y4"},   256'(y4),   256'(0));
    check({tag, "_vld4"}, 256'(vld4), 256'(0));
    check({tag, "_y1"},   256'(y1),   256'(0));
    check({tag, "_y8"},   y8,         256'(0));
    check({tag, "_vld8"}, 256'(vld8), 256'(0));
  endtask

  always @(posedge clk) begin : monitor
    exp_t x;
    #2;
    if (sb.size() != 0) begin
      x = sb.pop_front();
      check("y4",   256'(y4),   256'(x.y4));
      check("vld4", 256'(vld4), 256'(x.vld));
      check("y1",   256'(y1),   256'(x.y1));
      check("vld1", 256'(vld1), 256'(x.vld));
      check("y8",   y8,         x.y8);
      check("vld8", 256'(vld8), 256'(x.vld));
    end
  end

  initial begin
    #1;
    check_cleared("por");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Reset asserted with a live decode clears outputs without a clock edge and holds them.
    drive(1'b1, 4'd5, 1'b1, 8'd5, 16'h0020, 2'b10, 256'(1) << 5);
    @(posedge clk);
    #3 rst = 1'b1;
    #0.5;
    check_cleared("rst_async");
    repeat (2) begin
      @(posedge clk);
      #1 check_cleared("rst_hold");
    end
    @(negedge clk) rst = 1'b0;

    for (int k = 0; k < 16; k++)
      drive(1'b0, 4'(k), k[0], 8'(k * 17), 16'h0000, 2'b00, 256'(0));

    for (int k = 0; k < 16; k++)
      drive(1'b1, 4'(k), k[0], 8'(k * 17), 16'(1) << k,
            k[0] ? 2'b10 : 2'b01, 256'(1) << (k * 17));

    drive(1'b1, 4'd3, 1'b1, 8'd3, 16'h0008, 2'b10, 256'(1) << 3);
    drive(1'b0, 4'd3, 1'b1, 8'd3, 16'h0000, 2'b00, 256'(0));
    drive(1'b1, 4'd9, 1'b0, 8'd9, 16'h0200, 2'b01, 256'(1) << 9);

    // Short reset pulse between edges; the next edge re-captures the unchanged inputs.
    drive(1'b1, 4'd7, 1'b1, 8'd7, 16'h0080, 2'b10, 256'(1) << 7);
    @(posedge clk);
    #3 rst = 1'b1;
    #0.5;
    check_cleared("rst_mid");
    #0.5 rst = 1'b0;
    drive(1'b1, 4'd7, 1'b1, 8'd7, 16'h0080, 2'b10, 256'(1) << 7);

    drive(1'b0, 4'd0, 1'b0, 8'd0, 16'h0000, 2'b00, 256'(0));
    repeat (3) @(posedge clk);
    #3;
    check("drain", 256'(sb.size()), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
